rv32_redirect_ctrl: RTL and testbench
=====================================

# rv32_redirect_ctrl

Control-flow redirect controller between the execute stage and the fetch unit. Consumes the resolved branch decision (`do_branch` from the branch unit) with the fetch-time prediction, detects mispredictions, and drives a registered redirect request to fetch over a valid/ready handshake. It also holds a pipeline flush until fetch has accepted the new PC and its in-flight responses have drained.

## Interface
- `DRAIN_CYCLES`, default 1: cycles `flush` stays high after redirect acceptance; legal range 0..7.
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  valid instruction in EX this cycle.
- `ex_branch_op`  in  `branch_op_t`  branch operation of the EX instruction; any value other than `OP_BEQ`, `OP_BNE`, `OP_BLT`, `OP_BGE`, `OP_BLTU`, `OP_BGEU` or `OP_J` means "not a control-flow instruction".
- `ex_do_branch`  in  1  branch unit decision for the EX instruction.
- `ex_pc`  in  `rv32_word`  PC of the EX instruction.
- `ex_target`  in  `rv32_word`  computed taken target.
- `ex_pred_taken`  in  1  fetch predicted taken.
- `ex_pred_target`  in  `rv32_word`  fetch-predicted target; meaningful only when `ex_pred_taken` is 1.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_pc`  out  `rv32_word`  new fetch PC; stable while `redirect_valid` is 1.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `flush`  out  1  kill all instructions younger than the resolving one (IF, ID, EX).
- `target_misaligned`  out  1  one-cycle exception pulse.

## Operation
- `taken = ex_do_branch & is_cf(ex_branch_op)`.
- Mispredict when `ex_valid`, state is IDLE, and either of these holds:
  - `taken != ex_pred_taken`;
  - `taken & ex_pred_taken & (ex_target != ex_pred_target)`.
- Non-branch with `ex_pred_taken = 1` is a mispredict (aliasing); it redirects to `ex_pc + 4`.
- Target: `taken ? ex_target : ex_pc + 4`. Addition is 32-bit modulo, so `0xFFFFFFFC + 4 = 0x00000000`.
- Misalignment: `taken & (ex_target[1:0] != 0)`. This pulses `target_misaligned` next cycle and takes priority over redirect; state stays IDLE.
- FSM states:
  - IDLE: on mispredict, latch target into `redirect_pc` and go to REDIRECT.
  - REDIRECT: `redirect_valid = 1`, `flush = 1`. On `redirect_valid & redirect_ready`, go to DRAIN, or to IDLE if `DRAIN_CYCLES == 0`.
  - DRAIN: `flush = 1`, `redirect_valid = 0`, 3-bit down-counter loaded with `DRAIN_CYCLES - 1`. Go to IDLE when the counter reaches 0.
- All EX inputs are ignored outside IDLE; they are wrong-path, already covered by `flush`.
- `redirect_ready` without `redirect_valid` is ignored.
- Reset (at any time, including mid-REDIRECT or mid-DRAIN):
  - state returns to IDLE, counter clears;
  - `redirect_valid = 0`, `redirect_pc = 0`, `flush = 0`, `target_misaligned = 0`;
  - stats counters clear.
- All outputs are registered or decoded from registered state only; none is combinational from EX inputs.

## Timing
- Mispredict resolved in EX at cycle N: `redirect_valid` and `flush` go high at N+1.
- Handshake completes at cycle M ≥ N+1 (same-cycle ready allowed, so M = N+1 is possible).
- `flush` is high for cycles M+1 .. M+`DRAIN_CYCLES`.
- IDLE at M+`DRAIN_CYCLES`+1; first new resolution is accepted that cycle.
- Minimum redirect-to-resolve gap with `DRAIN_CYCLES=1` and ready held high: 3 cycles.
- `target_misaligned`: high exactly at N+1 for one cycle.
- Correctly predicted branches produce no output activity.

## Configuration
- `RV_REDIRECT_STATS_EN` defined:
  - adds outputs `stat_branches` and `stat_mispredicts` (`rv32_word` each).
  - `stat_branches` increments per `ex_valid` control-flow instruction evaluated in IDLE.
  - `stat_mispredicts` increments per mispredict that enters REDIRECT.
  - Counters wrap at 2^32 and reset to 0.
- Not defined: ports and counters are absent; all other behaviour is identical.

## Test plan
- **Correct prediction:** `OP_BEQ`, `do_branch=1`, `pred_taken=1`, `pred_target=ex_target=0x100` → `redirect_valid` and `flush` stay 0.
- **Not-taken mispredict:** `OP_BNE`, `do_branch=0`, `pred_taken=1`, `ex_pc=0x200`, ready=1 → at N+1 `redirect_valid=1`, `redirect_pc=0x204`; `flush` high at N+1 and N+2; IDLE at N+3.
- **Backpressure:** `OP_J`, `pred_taken=0`, `ex_target=0x80`, ready held 0 for 4 cycles → `redirect_valid` and `flush` held, `redirect_pc=0x80` stable; a new mispredicting EX input during the wait is ignored.
- **Misalignment:** `OP_J` with `ex_target=0x102` → `target_misaligned` pulses one cycle at N+1; no redirect; `flush` stays 0.
- **Wrap and drain:** `ex_pc=0xFFFFFFFC`, aliasing mispredict, `DRAIN_CYCLES=3` → `redirect_pc=0x0`; `flush` high for 3 cycles after acceptance.
- **Reset mid-operation:** assert `resetn=0` mid-DRAIN → all outputs 0 immediately, without waiting for a clock edge. With `RV_REDIRECT_STATS_EN`, after 5 branches including 2 mispredicts, `stat_branches=5` and `stat_mispredicts=2`.

Source files
------------

// File: rtl/rv32_redirect_ctrl.sv
// rv32_redirect_ctrl
// ------------------------------------------------------------------
// Control-flow redirect controller sitting between EX and fetch.
// It compares the resolved branch decision against the fetch-time
// prediction. On a mispredict it raises a registered redirect request
// toward fetch over a valid/ready handshake. It then holds a pipeline
// flush until fetch has accepted the new PC and DRAIN_CYCLES further
// cycles have passed. Misaligned taken targets raise a one-cycle
// exception pulse instead of a redirect.
//
// Parameters:
//   DRAIN_CYCLES      cycles flush stays high after redirect acceptance (0..7)
//
// Ports:
//   clk               clock, rising edge
//   resetn            asynchronous active-low reset
//   ex_valid          valid instruction in EX
//   ex_branch_op      branch operation of the EX instruction
//   ex_do_branch      branch unit decision
//   ex_pc             PC of the EX instruction
//   ex_target         computed taken target
//   ex_pred_taken     fetch predicted taken
//   ex_pred_target    fetch predicted target
//   redirect_valid    redirect request to fetch
//   redirect_pc       new fetch PC, stable while redirect_valid is high
//   redirect_ready    fetch accepts the redirect
//   flush             kill IF/ID/EX instructions
//   target_misaligned one-cycle misaligned-target exception pulse
//   stat_branches     (RV_REDIRECT_STATS_EN) evaluated control-flow count
//   stat_mispredicts  (RV_REDIRECT_STATS_EN) redirects issued count
//
// Optional feature macro: RV_REDIRECT_STATS_EN adds the two stats counters.
// ------------------------------------------------------------------

package rv32_redirect_pkg;

    typedef logic [31:0] rv32_word;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_BEQ   = 4'd1,
        OP_BNE   = 4'd2,
        OP_BLT   = 4'd3,
        OP_BGE   = 4'd4,
        OP_BLTU  = 4'd5,
        OP_BGEU  = 4'd6,
        OP_J     = 4'd7,
        OP_ALU   = 4'd8,
        OP_LOAD  = 4'd9,
        OP_STORE = 4'd10
    } branch_op_t;

endpackage

module rv32_redirect_ctrl
    import rv32_redirect_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ex_valid,
    input  branch_op_t ex_branch_op,
    input  logic       ex_do_branch,
    input  rv32_word   ex_pc,
    input  rv32_word   ex_target,
    input  logic       ex_pred_taken,
    input  rv32_word   ex_pred_target,
    output logic       redirect_valid,
    output rv32_word   redirect_pc,
    input  logic       redirect_ready,
    output logic       flush,
    output logic       target_misaligned
`ifdef RV_REDIRECT_STATS_EN
    ,
    output rv32_word   stat_branches,
    output rv32_word   stat_mispredicts
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    // The drain counter counts down to zero, so it starts one below the
    // number of flush cycles wanted after acceptance.
    localparam logic [2:0] DRAIN_LOAD =
        (DRAIN_CYCLES == 0) ? 3'd0 : 3'(DRAIN_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] drain_cnt;
    logic       load_redirect;
    logic       load_drain;

    logic       in_idle;
    logic       is_cf;
    logic       taken;
    logic       misalign_evt;
    logic       mispredict;
    rv32_word   new_target;

    assign in_idle = (state == S_IDLE);

    always_comb begin
        is_cf = 1'b0;
        case (ex_branch_op)
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_J: is_cf = 1'b1;
            default: is_cf = 1'b0;
        endcase
    end

    assign taken        = ex_do_branch & is_cf;
    assign new_target   = taken ? ex_target : (ex_pc + 32'd4);

    // EX inputs only matter in IDLE; anything seen while busy is wrong-path.
    // A misaligned taken target suppresses the redirect entirely.
    assign misalign_evt = in_idle & ex_valid & taken & (ex_target[1:0] != 2'b00);
    assign mispredict   = in_idle & ex_valid & ~misalign_evt &
                          ((taken != ex_pred_taken) |
                           (taken & ex_pred_taken & (ex_target != ex_pred_target)));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= S_IDLE;
            drain_cnt         <= 3'd0;
            redirect_pc       <= '0;
            target_misaligned <= 1'b0;
        end else begin
            state             <= state_next;
            target_misaligned <= misalign_evt;
            if (load_redirect) begin
                redirect_pc <= new_target;
            end
            if (load_drain) begin
                drain_cnt <= DRAIN_LOAD;
            end else if ((state == S_DRAIN) && (drain_cnt != 3'd0)) begin
                drain_cnt <= drain_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        load_redirect  = 1'b0;
        load_drain     = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (mispredict) begin
                    state_next    = S_REDIRECT;
                    load_redirect = 1'b1;
                end
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                if (redirect_ready) begin
                    load_drain = 1'b1;
                    state_next = (DRAIN_CYCLES == 0) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                flush = 1'b1;
                if (drain_cnt == 3'd0) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef RV_REDIRECT_STATS_EN
    // Branch count covers every evaluated control-flow instruction,
    // including misaligned ones; mispredicts count only real redirects.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (in_idle & ex_valid & is_cf) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32_redirect_ctrl.sv
// tb_rv32_redirect_ctrl
// ------------------------------------------------------------------
// Self-checking bench for rv32_redirect_ctrl. Two instances share the
// same stimulus: one with DRAIN_CYCLES=1 and one with DRAIN_CYCLES=3.
// Each is compared every cycle against a behavioural model that tracks
// "redirect outstanding" plus "flush cycles still owed".
// ------------------------------------------------------------------

module tb_rv32_redirect_ctrl;
    import rv32_redirect_pkg::*;

    logic       clk;
    logic       resetn;
    logic       ex_valid;
    branch_op_t ex_branch_op;
    logic       ex_do_branch;
    rv32_word   ex_pc;
    rv32_word   ex_target;
    logic       ex_pred_taken;
    rv32_word   ex_pred_target;
    logic       redirect_ready;

    logic       rv_o [2];
    rv32_word   pc_o [2];
    logic       fl_o [2];
    logic       tm_o [2];
`ifdef RV_REDIRECT_STATS_EN
    rv32_word   sb_o [2];
    rv32_word   sm_o [2];
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state per instance.
    int          drain_cfg [2] = '{1, 3};
    bit          m_pending [2];
    int          m_drain   [2];
    rv32_word    m_pc      [2];
    bit          m_mis     [2];
    int unsigned m_br      [2];
    int unsigned m_mp      [2];

    rv32_redirect_ctrl #(.DRAIN_CYCLES(1)) dut1 (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_branch_op(ex_branch_op),
        .ex_do_branch(ex_do_branch), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(rv_o[0]), .redirect_pc(pc_o[0]), .redirect_ready(redirect_ready),
        .flush(fl_o[0]), .target_misaligned(tm_o[0])
`ifdef RV_REDIRECT_STATS_EN
        , .stat_branches(sb_o[0]), .stat_mispredicts(sm_o[0])
`endif
    );

    rv32_redirect_ctrl #(.DRAIN_CYCLES(3)) dut3 (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_branch_op(ex_branch_op),
        .ex_do_branch(ex_do_branch), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(rv_o[1]), .redirect_pc(pc_o[1]), .redirect_ready(redirect_ready),
        .flush(fl_o[1]), .target_misaligned(tm_o[1])
`ifdef RV_REDIRECT_STATS_EN
        , .stat_branches(sb_o[1]), .stat_mispredicts(sm_o[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit isControlFlow(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_pending[i] = 1'b0;
            m_drain[i]   = 0;
            m_pc[i]      = '0;
            m_mis[i]     = 1'b0;
            m_br[i]      = 0;
            m_mp[i]      = 0;
        end
    endtask

    // One clock of the reference model, using the inputs present at the edge.
    task automatic modelClock();
        bit cf;
        bit tk;
        cf = isControlFlow(ex_branch_op);
        tk = ex_do_branch && cf;
        for (int i = 0; i < 2; i++) begin
            m_mis[i] = 1'b0;
            if (m_pending[i]) begin
                if (redirect_ready) begin
                    m_pending[i] = 1'b0;
                    m_drain[i]   = drain_cfg[i];
                end
            end else if (m_drain[i] > 0) begin
                m_drain[i]--;
            end else if (ex_valid) begin
                if (cf) m_br[i]++;
                if (tk && (ex_target % 4 != 0)) begin
                    m_mis[i] = 1'b1;
                end else if ((tk != ex_pred_taken) ||
                             (tk && ex_target != ex_pred_target)) begin
                    m_pending[i] = 1'b1;
                    m_pc[i]      = tk ? ex_target : ex_pc + 32'd4;
                    m_mp[i]++;
                end
            end
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("redirect_valid[%0d]", i), 32'(rv_o[i]), 32'(m_pending[i]));
            checkOutput($sformatf("flush[%0d]", i), 32'(fl_o[i]),
                        32'(m_pending[i] || (m_drain[i] > 0)));
            checkOutput($sformatf("target_misaligned[%0d]", i), 32'(tm_o[i]), 32'(m_mis[i]));
            if (m_pending[i]) begin
                checkOutput($sformatf("redirect_pc[%0d]", i), pc_o[i], m_pc[i]);
            end
`ifdef RV_REDIRECT_STATS_EN
            checkOutput($sformatf("stat_branches[%0d]", i), sb_o[i], m_br[i]);
            checkOutput($sformatf("stat_mispredicts[%0d]", i), sm_o[i], m_mp[i]);
`endif
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("%s redirect_valid[%0d]", tag, i), 32'(rv_o[i]), 32'd0);
            checkOutput($sformatf("%s redirect_pc[%0d]", tag, i), pc_o[i], 32'd0);
            checkOutput($sformatf("%s flush[%0d]", tag, i), 32'(fl_o[i]), 32'd0);
            checkOutput($sformatf("%s target_misaligned[%0d]", tag, i), 32'(tm_o[i]), 32'd0);
        end
    endtask

    task automatic applyStimulus(input logic v, input branch_op_t op, input logic db,
                                 input rv32_word pc, input rv32_word tgt,
                                 input logic pt, input rv32_word ptgt);
        ex_valid       = v;
        ex_branch_op   = op;
        ex_do_branch   = db;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic idleEx();
        applyStimulus(1'b0, OP_NONE, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Clock once, advance the model, and compare one time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (resetn) modelClock();
        #1;
        compareAll();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) begin
            step();
        end
    endtask

    initial begin
        resetn         = 1'b0;
        redirect_ready = 1'b0;
        idleEx();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        resetn = 1'b1;

        // Correct prediction: no activity.
        redirect_ready = 1'b1;
        applyStimulus(1'b1, OP_BEQ, 1'b1, 32'h40, 32'h100, 1'b1, 32'h100);
        step();
        idleEx();
        steps(2);

        // Not-taken mispredict, ready high.
        applyStimulus(1'b1, OP_BNE, 1'b0, 32'h200, 32'h300, 1'b1, 32'h300);
        step();
        checkOutput("nt_mispredict redirect_pc", pc_o[0], 32'h204);
        idleEx();
        steps(5);

        // Backpressure with a competing mispredict while waiting.
        redirect_ready = 1'b0;
        applyStimulus(1'b1, OP_J, 1'b1, 32'h10, 32'h80, 1'b0, 32'h0);
        step();
        applyStimulus(1'b1, OP_BNE, 1'b0, 32'h500, 32'h600, 1'b1, 32'h600);
        step();
        idleEx();
        steps(2);
        checkOutput("backpressure redirect_pc", pc_o[0], 32'h80);
        redirect_ready = 1'b1;
        steps(5);

        // Misaligned jump target.
        applyStimulus(1'b1, OP_J, 1'b1, 32'h20, 32'h102, 1'b0, 32'h0);
        step();
        idleEx();
        steps(2);

        // Aliasing mispredict at the top of the address space.
        applyStimulus(1'b1, OP_ALU, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h1234);
        step();
        checkOutput("wrap redirect_pc", pc_o[1], 32'h0);
        idleEx();
        steps(6);

        // Reset asserted while both instances are draining.
        applyStimulus(1'b1, OP_BLT, 1'b1, 32'h700, 32'h800, 1'b0, 32'h0);
        step();
        idleEx();
        step();
        #2;
        resetn = 1'b0;
        #1;
        modelReset();
        checkResetState("async_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

`ifdef RV_REDIRECT_STATS_EN
        // Five branches, two of which mispredict.
        applyStimulus(1'b1, OP_BEQ, 1'b1, 32'h0, 32'h40, 1'b1, 32'h40);
        step();
        applyStimulus(1'b1, OP_BGE, 1'b0, 32'h4, 32'h40, 1'b0, 32'h0);
        step();
        applyStimulus(1'b1, OP_BLTU, 1'b1, 32'h8, 32'h40, 1'b0, 32'h0);
        step();
        idleEx();
        steps(6);
        applyStimulus(1'b1, OP_BGEU, 1'b1, 32'hC, 32'h44, 1'b1, 32'h48);
        step();
        idleEx();
        steps(6);
        applyStimulus(1'b1, OP_J, 1'b1, 32'h10, 32'h80, 1'b1, 32'h80);
        step();
        idleEx();
        step();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("stats branches[%0d]", i), sb_o[i], 32'd5);
            checkOutput($sformatf("stats mispredicts[%0d]", i), sm_o[i], 32'd2);
        end
`endif

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            rv32_word tgt;
            tgt = {$urandom_range(0, 255), 2'b00} | 32'h1000;
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            applyStimulus(($urandom_range(0, 3) != 0),
                          branch_op_t'($urandom_range(0, 11)),
                          1'($urandom_range(0, 1)),
                          {$urandom_range(0, 1023), 2'b00},
                          tgt,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) != 0) ? tgt : tgt + 32'd4);
            redirect_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
